// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared state type and sizing for the mux select scanner
package mux_sel_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: first set request at or above start, wrapping around 8 channels
module rr_prio_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);
  logic [SEL_W-1:0] w_c;
  always_comb begin
    found = 1'b0;
    idx = start;
    w_c = start;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_c = start + SEL_W'(k);
      if (req[w_c]) begin
        found = 1'b1;
        idx = w_c;
      end
    end
  end
endmodule

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin dwell scanner driving the select lines of an 8:1 mux
module mux_sel_scanner #(
  parameter int DWELL_W = 4,
  parameter int NUM_CH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [7:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               sel_valid,
  output logic               done
);
  import mux_sel_pkg::*;
  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [SEL_W-1:0]   r_last;
  logic [SEL_W-1:0]   r_sel;
  logic               r_valid;
  logic [SEL_W-1:0]   w_start;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic               w_last_cyc;
  // at the end of a hold, last_ptr becomes the current channel, so search past it directly
  assign w_start = (r_state == HOLD) ? r_sel + 1'b1 : r_last + 1'b1;
  assign w_last_cyc = (r_state == HOLD) && (r_cnt == '0);
  assign done = w_last_cyc && en;
  assign {s2, s1, s0} = r_sel;
  assign sel_valid = r_valid;
  rr_prio_pick u_pick (
    .req   (req),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= SEL_W'(NUM_CH - 1);
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (en && w_found) begin
        r_sel   <= w_idx;
        r_cnt   <= dwell;
        r_valid <= 1'b1;
        r_state <= HOLD;
      end
    end else if (!en) begin
      r_last  <= r_sel;
      r_valid <= 1'b0;
      r_state <= IDLE;
    end else if (!w_last_cyc) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      r_last <= r_sel;
      if (w_found) begin
        r_sel <= w_idx;
        r_cnt <= dwell;
      end else begin
        r_valid <= 1'b0;
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: directed checks of grant order, dwell, abort and reset behaviour
module tb_mux_sel_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic [3:0] dwell = '0;
  logic       s2, s1, s0, sel_valid, done;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  mux_sel_scanner #(.DWELL_W(4), .NUM_CH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .dwell     (dwell),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .sel_valid (sel_valid),
    .done      (done)
  );

  function automatic logic [4:0] e(input logic v, input int ch, input logic d);
    logic [2:0] c;
    c = 3'(ch);
    return {v, c, d};
  endfunction

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {sel_valid, s2, s1, s0, done};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed valid/sel/done=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; dwell = 4'd3;
    @(negedge clk); chk("reset_a", e(0, 0, 0));
    @(negedge clk); chk("reset_b", e(0, 0, 0));
    rst_n = 1'b1; req = 8'h05; dwell = 4'd2; en = 1'b1;
    @(negedge clk); chk("two_ch0_1", e(1, 0, 0));
    req = 8'h04;
    @(negedge clk); chk("two_ch0_2", e(1, 0, 0));
    @(negedge clk); chk("two_ch0_3", e(1, 0, 1));
    req = 8'h05;
    @(negedge clk); chk("two_ch2_1", e(1, 2, 0));
    @(negedge clk); chk("two_ch2_2", e(1, 2, 0));
    @(negedge clk); chk("two_ch2_3", e(1, 2, 1));
    @(negedge clk); chk("two_ch0_again", e(1, 0, 0));
    en = 1'b0;
    @(negedge clk); chk("idle_hold_sel", e(0, 0, 0));
    req = 8'h80; dwell = 4'd1; en = 1'b1;
    @(negedge clk); chk("single_1", e(1, 7, 0));
    @(negedge clk); chk("single_2", e(1, 7, 1));
    @(negedge clk); chk("single_3", e(1, 7, 0));
    @(negedge clk); chk("single_4", e(1, 7, 1));
    en = 1'b0;
    #1 chk("done_needs_en", e(1, 7, 0));
    @(negedge clk); chk("single_stop", e(0, 7, 0));
    req = 8'h08; dwell = 4'd5; en = 1'b1;
    @(negedge clk); chk("abort_hold1", e(1, 3, 0));
    @(negedge clk); chk("abort_hold2", e(1, 3, 0));
    en = 1'b0;
    @(negedge clk); chk("abort_idle", e(0, 3, 0));
    req = 8'h18; en = 1'b1;
    @(negedge clk); chk("resume_ch4", e(1, 4, 0));
    en = 1'b0;
    @(negedge clk); chk("idle_ch4", e(0, 4, 0));
    req = 8'h20; dwell = 4'd3; en = 1'b1;
    @(negedge clk); chk("rst_ch5_1", e(1, 5, 0));
    @(negedge clk); chk("rst_ch5_2", e(1, 5, 0));
    rst_n = 1'b0; req = 8'h22;
    #2 chk("async_reset", e(0, 0, 0));
    @(negedge clk); chk("reset_held", e(0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk); chk("after_rst_ch1", e(1, 1, 0));
    rst_n = 1'b0;
    @(negedge clk); chk("reset_c", e(0, 0, 0));
    rst_n = 1'b1; req = 8'hFF; dwell = 4'd0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); chk($sformatf("all_req_%0d", i), e(1, i % 8, 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
